// File: rtl/cpu_pkg.sv
// Shared RV32I multicycle CPU definitions.
// Opcodes, ALU and write-back selects, FSM states, trap causes.
package cpu_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_L  = 7'b0000011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [2:0] {
    RFWD_ALU   = 3'b000,
    RFWD_LOAD  = 3'b001,
    RFWD_LUI   = 3'b010,
    RFWD_AUIPC = 3'b011,
    RFWD_PC4   = 3'b100
  } rfwd_e;

  typedef enum logic [3:0] {
    FETCH, DECODE,
    R_EXE, I_EXE, B_EXE,
    LU_EXE, AU_EXE,
    J_EXE, JL_EXE,
    S_EXE, S_MEM,
    L_EXE, L_MEM, L_WB,
    TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_e;

  function automatic state_e decode_state(
    input logic [6:0] op,
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       strict
  );
    logic bad;
    bad = 1'b0;
    decode_state = TRAP;
    unique case (1'b1)
      (op == OP_R): begin
        bad = strict && !(f7 == F7_BASE ||
          (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
        decode_state = bad ? TRAP : R_EXE;
      end
      (op == OP_I): begin
        bad = strict && (
          (f3 == 3'b001 && f7 != F7_BASE) ||
          (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT));
        decode_state = bad ? TRAP : I_EXE;
      end
      (op == OP_B):  decode_state = B_EXE;
      (op == OP_LU): decode_state = LU_EXE;
      (op == OP_AU): decode_state = AU_EXE;
      (op == OP_J):  decode_state = J_EXE;
      (op == OP_JL): decode_state = JL_EXE;
      (op == OP_S):  decode_state = S_EXE;
      (op == OP_L):  decode_state = L_EXE;
      default:       decode_state = TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_bus_wait_timer.sv
// Bus wait-state watchdog for the multicycle control FSM.
// expired flags the last allowed not-ready cycle of a wait.
module mc_bus_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic busReady,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q;

  assign expired = waiting && !busReady && (cnt_q == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!waiting || busReady) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mc_control_unit_hs.sv
// Multicycle RV32I control FSM with handshaked memory access,
// illegal/timeout trapping and a retired-instruction counter.
module mc_control_unit_hs
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32,
  parameter int STRICT_DECODE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             busReady,
  output logic             PCEn,
  output logic             irWe,
  output logic             regFileWe,
  output logic [3:0]       aluControl,
  output logic             aluSrcMuxSel,
  output logic             busRe,
  output logic             busWe,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic [1:0]       LSControl,
  output logic             SignControl,
  output logic             trap,
  output logic [1:0]       trapCause,
  output logic [CNT_W-1:0] retiredCnt
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  rfwd_e       rfwd;
  logic        waiting, expired;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       unused_bits;

  assign op = instrCode[6:0];
  assign f3 = instrCode[14:12];
  assign f7 = instrCode[31:25];
  assign unused_bits = ^{instrCode[24:15], instrCode[11:7]};

  assign LSControl     = instrCode[13:12];
  assign SignControl   = instrCode[14];
  assign RFWDSrcMuxSel = rfwd;
  assign trapCause     = cause_q;

  assign waiting = (state_q == FETCH) ||
                   (state_q == S_MEM) ||
                   (state_q == L_MEM);

  mc_bus_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .waiting (waiting),
    .busReady(busReady),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      cause_q    <= CAUSE_NONE;
      retiredCnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != TRAP && state_d == TRAP) begin
        cause_q <= cause_d;
      end
      if (state_q != FETCH && state_d == FETCH) begin
        retiredCnt <= retiredCnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cause_d      = CAUSE_NONE;
    PCEn         = 1'b0;
    irWe         = 1'b0;
    regFileWe    = 1'b0;
    aluControl   = ALU_ADD;
    aluSrcMuxSel = 1'b0;
    busRe        = 1'b0;
    busWe        = 1'b0;
    rfwd         = RFWD_ALU;
    branch       = 1'b0;
    jal          = 1'b0;
    jalr         = 1'b0;
    trap         = 1'b0;
    unique case (state_q)
      FETCH: begin
        busRe = 1'b1;
        if (busReady) begin
          irWe    = 1'b1;
          PCEn    = 1'b1;
          state_d = DECODE;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        state_d = decode_state(op, f3, f7,
                               STRICT_DECODE != 0);
        if (state_d == TRAP) cause_d = CAUSE_ILLEGAL;
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {instrCode[30], f3};
        state_d    = FETCH;
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        // only shifts carry the arithmetic bit in the immediate
        aluControl   = (f3 == 3'b101) ?
                       {instrCode[30], f3} : {1'b0, f3};
        state_d      = FETCH;
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {instrCode[30], f3};
        state_d    = FETCH;
      end
      LU_EXE: begin
        regFileWe = 1'b1;
        rfwd      = RFWD_LUI;
        state_d   = FETCH;
      end
      AU_EXE: begin
        regFileWe = 1'b1;
        rfwd      = RFWD_AUIPC;
        state_d   = FETCH;
      end
      J_EXE: begin
        regFileWe = 1'b1;
        rfwd      = RFWD_PC4;
        jal       = 1'b1;
        state_d   = FETCH;
      end
      JL_EXE: begin
        regFileWe = 1'b1;
        rfwd      = RFWD_PC4;
        jal       = 1'b1;
        jalr      = 1'b1;
        state_d   = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        state_d      = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        if (busReady) begin
          state_d = FETCH;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
        rfwd         = RFWD_LOAD;
        state_d      = L_MEM;
      end
      L_MEM: begin
        busRe = 1'b1;
        if (busReady) begin
          state_d = L_WB;
        end else if (expired) begin
          state_d = TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      L_WB: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        rfwd         = RFWD_LOAD;
        state_d      = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// Scoreboard bench for mc_control_unit_hs: per-instruction
// reference programs push expected cycles, a monitor compares.
module tb_mc_control_unit_hs;

  localparam int T  = 15;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        busReady;
  logic [31:0] instrCode;

  logic          PCEn, irWe, regFileWe, aluSrcMuxSel;
  logic          busRe, busWe, branch, jal, jalr;
  logic          SignControl, trap;
  logic [3:0]    aluControl;
  logic [2:0]    RFWDSrcMuxSel;
  logic [1:0]    LSControl, trapCause;
  logic [CW-1:0] retiredCnt;

  logic        l_pcen, l_irwe, l_rfwe, l_alusrc;
  logic        l_busre, l_buswe, l_br, l_jal, l_jalr;
  logic        l_sign, l_trap;
  logic [3:0]  l_alu;
  logic [2:0]  l_rfwd;
  logic [1:0]  l_ls, l_cause;
  logic [31:0] l_cnt;

  mc_control_unit_hs #(
    .TIMEOUT_CYCLES(T), .CNT_W(CW), .STRICT_DECODE(1)
  ) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode),
    .busReady(busReady), .PCEn(PCEn), .irWe(irWe),
    .regFileWe(regFileWe), .aluControl(aluControl),
    .aluSrcMuxSel(aluSrcMuxSel), .busRe(busRe),
    .busWe(busWe), .RFWDSrcMuxSel(RFWDSrcMuxSel),
    .branch(branch), .jal(jal), .jalr(jalr),
    .LSControl(LSControl), .SignControl(SignControl),
    .trap(trap), .trapCause(trapCause),
    .retiredCnt(retiredCnt)
  );

  mc_control_unit_hs #(
    .TIMEOUT_CYCLES(T), .CNT_W(32), .STRICT_DECODE(0)
  ) lax (
    .clk(clk), .reset(reset), .instrCode(instrCode),
    .busReady(busReady), .PCEn(l_pcen), .irWe(l_irwe),
    .regFileWe(l_rfwe), .aluControl(l_alu),
    .aluSrcMuxSel(l_alusrc), .busRe(l_busre),
    .busWe(l_buswe), .RFWDSrcMuxSel(l_rfwd),
    .branch(l_br), .jal(l_jal), .jalr(l_jalr),
    .LSControl(l_ls), .SignControl(l_sign),
    .trap(l_trap), .trapCause(l_cause),
    .retiredCnt(l_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pcen, irwe, rfwe;
    logic [3:0]    alu;
    logic          alusrc, busre, buswe;
    logic [2:0]    rfwd;
    logic          br, jal, jalr;
    logic [1:0]    ls;
    logic          sign, trap;
    logic [1:0]    cause;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    exp_t e;
    logic lax;
  } item_t;

  item_t q[$];
  bit    rdyq[$];
  int    checks = 0;
  int    fails  = 0;

  logic [CW-1:0] m_cnt;
  logic          m_trap;
  logic [1:0]    m_cause;

  item_t mon_it;
  exp_t  mon_act;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_it = q.pop_front();
      mon_act.pcen   = PCEn;
      mon_act.irwe   = irWe;
      mon_act.rfwe   = regFileWe;
      mon_act.alu    = aluControl;
      mon_act.alusrc = aluSrcMuxSel;
      mon_act.busre  = busRe;
      mon_act.buswe  = busWe;
      mon_act.rfwd   = RFWDSrcMuxSel;
      mon_act.br     = branch;
      mon_act.jal    = jal;
      mon_act.jalr   = jalr;
      mon_act.ls     = LSControl;
      mon_act.sign   = SignControl;
      mon_act.trap   = trap;
      mon_act.cause  = trapCause;
      mon_act.cnt    = retiredCnt;
      checks++;
      if (mon_act !== mon_it.e) begin
        fails++;
        $display("FAIL outputs t=%0t ir=%h got=%h want=%h",
                 $time, instrCode, mon_act, mon_it.e);
      end
      if (mon_it.lax) begin
        checks++;
        if ({l_rfwe, l_alu, l_trap} !== 6'b1_0000_0) begin
          fails++;
          $display("FAIL lax_decode got=%b want=%b",
                   {l_rfwe, l_alu, l_trap}, 6'b1_0000_0);
        end
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e       = '0;
    e.ls    = instrCode[13:12];
    e.sign  = instrCode[14];
    e.trap  = m_trap;
    e.cause = m_cause;
    e.cnt   = m_cnt;
    return e;
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit next_rdy();
    if (rdyq.size() > 0) return rdyq.pop_front();
    return $urandom_range(0, 9) < 6;
  endfunction

  function automatic bit legal(input logic [31:0] i,
                               input bit strict);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0];
    f7 = i[31:25];
    f3 = i[14:12];
    case (op)
      7'b0110011:
        return !strict || f7 == 7'h00 ||
               (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      7'b0010011: begin
        if (!strict) return 1'b1;
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
        return 1'b1;
      end
      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
      7'b1100111, 7'b0100011, 7'b0000011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input exp_t e, input bit r,
                      input bit lx = 1'b0);
    item_t it;
    busReady = r;
    it.e   = e;
    it.lax = lx;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // one bus wait: ready ends it, T not-ready cycles trap
  task automatic wait_ph(input exp_t e, input bit isf,
                         output bit ok);
    int   n;
    bit   r;
    exp_t x;
    n  = 0;
    ok = 1'b0;
    while (1) begin
      r = next_rdy();
      x = e;
      if (isf && r) begin
        x.irwe = 1'b1;
        x.pcen = 1'b1;
      end
      step(x, r);
      if (r) begin
        ok = 1'b1;
        return;
      end
      n++;
      if (n == T) begin
        m_trap  = 1'b1;
        m_cause = 2'b10;
        return;
      end
    end
  endtask

  task automatic retire();
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic run_instr(input logic [31:0] ins,
                           input bit lx = 1'b0);
    exp_t       e;
    bit         ok;
    logic [2:0] f3;
    e = base();
    e.busre = 1'b1;
    wait_ph(e, 1'b1, ok);
    if (!ok) return;
    instrCode = ins;
    f3 = ins[14:12];
    step(base(), rnd());
    if (!legal(ins, 1'b1)) begin
      m_trap  = 1'b1;
      m_cause = 2'b01;
      if (lx) step(base(), rnd(), 1'b1);
      return;
    end
    e = base();
    case (ins[6:0])
      7'b0100011: begin
        e.alusrc = 1'b1;
        step(e, rnd());
        e.buswe = 1'b1;
        wait_ph(e, 1'b0, ok);
        if (ok) retire();
        return;
      end
      7'b0000011: begin
        e.alusrc = 1'b1;
        e.rfwd   = 3'd1;
        step(e, rnd());
        e = base();
        e.busre = 1'b1;
        wait_ph(e, 1'b0, ok);
        if (!ok) return;
        e = base();
        e.rfwe   = 1'b1;
        e.alusrc = 1'b1;
        e.rfwd   = 3'd1;
        step(e, rnd());
        retire();
        return;
      end
      7'b0110011: begin
        e.rfwe = 1'b1;
        e.alu  = {ins[30], f3};
      end
      7'b0010011: begin
        e.rfwe   = 1'b1;
        e.alusrc = 1'b1;
        e.alu    = {f3 == 3'd5 ? ins[30] : 1'b0, f3};
      end
      7'b1100011: begin
        e.br  = 1'b1;
        e.alu = {ins[30], f3};
      end
      7'b0110111: begin e.rfwe = 1'b1; e.rfwd = 3'd2; end
      7'b0010111: begin e.rfwe = 1'b1; e.rfwd = 3'd3; end
      7'b1101111: begin
        e.rfwe = 1'b1; e.rfwd = 3'd4; e.jal = 1'b1;
      end
      default: begin
        e.rfwe = 1'b1; e.rfwd = 3'd4;
        e.jal  = 1'b1; e.jalr = 1'b1;
      end
    endcase
    step(e, rnd());
    retire();
  endtask

  task automatic do_reset();
    exp_t e;
    reset   = 1'b1;
    m_cnt   = '0;
    m_trap  = 1'b0;
    m_cause = 2'b00;
    e = base();
    e.busre = 1'b1;
    step(e, 1'b0);
    reset = 1'b0;
  endtask

  task automatic trap_cycles(input int k);
    repeat (k) step(base(), rnd());
  endtask

  task automatic fetch_wait(input int k);
    exp_t e;
    e = base();
    e.busre = 1'b1;
    repeat (k) step(e, 1'b0);
  endtask

  task automatic ready_n(input int zeros);
    repeat (zeros) rdyq.push_back(1'b0);
    rdyq.push_back(1'b1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [2:0]  f3;
    i  = $urandom;
    f3 = i[14:12];
    case ($urandom_range(0, 11))
      0: begin
        i[6:0] = 7'b0110011;
        i[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && rnd()) ?
                   7'h20 : 7'h00;
      end
      1: begin
        i[6:0] = 7'b0010011;
        if (f3 == 3'd1) i[31:25] = 7'h00;
        if (f3 == 3'd5) i[31:25] = rnd() ? 7'h20 : 7'h00;
      end
      2:  i[6:0] = 7'b1100011;
      3:  i[6:0] = 7'b0110111;
      4:  i[6:0] = 7'b0010111;
      5:  i[6:0] = 7'b1101111;
      6:  i[6:0] = 7'b1100111;
      7:  i[6:0] = 7'b0100011;
      8:  i[6:0] = 7'b0000011;
      9:  ;
      10: i[6:0] = 7'b0110011;
      default: begin
        i[6:0]   = 7'b0010011;
        i[14:12] = rnd() ? 3'd1 : 3'd5;
      end
    endcase
    return i;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    busReady  = 1'b0;
    instrCode = 32'h0;
    m_cnt     = '0;
    m_trap    = 1'b0;
    m_cause   = 2'b00;
    @(posedge clk);
    #1;
    do_reset();

    ready_n(0); run_instr(32'h002081B3);
    ready_n(0); run_instr(32'h402081B3);
    ready_n(0); run_instr(32'h4020D093);
    ready_n(0); run_instr(32'h00108093);

    ready_n(0); ready_n(3); run_instr(32'h0000A283);

    ready_n(0);
    repeat (T) rdyq.push_back(1'b0);
    run_instr(32'h0020A223);
    trap_cycles(3);
    do_reset();

    ready_n(0); run_instr(32'hFFFFFFFF);
    trap_cycles(3);
    do_reset();

    ready_n(0); run_instr(32'h202081B3, 1'b1);
    trap_cycles(2);
    do_reset();

    repeat (17) begin
      ready_n(0);
      run_instr(32'h00108093);
    end

    fetch_wait(10);
    do_reset();
    ready_n(T - 1);
    run_instr(32'h00108093);

    ready_n(T - 1); run_instr(32'h00112023);
    ready_n(0); ready_n(T - 1); run_instr(32'h00012083);

    for (int n = 0; n < 400; n++) begin
      run_instr(rand_instr());
      if (m_trap) begin
        trap_cycles(2);
        do_reset();
      end else if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
